// File: rtl/id_ex_decode_stage_if.sv
// Decode-stage bus: fetch-side handshake, flush, and the registered ID/EX fields.
// The stage takes the slave modport; the fetch/execute environment drives the master side.
interface id_ex_decode_stage_if #(
    parameter int XLEN = 32
) ();
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_inst;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_ir;
    logic [3:0]      out_ctrl;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [4:0]      out_rd;
    logic [XLEN-1:0] out_imm;
    logic            out_use_imm;
    logic            out_is_load;
    logic            out_reg_write;
    logic            out_illegal;

    modport slave (
        input  flush, in_valid, in_inst, out_ready,
        output in_ready, out_valid, out_ir, out_ctrl, out_rs1, out_rs2, out_rd,
               out_imm, out_use_imm, out_is_load, out_reg_write, out_illegal
    );

    modport master (
        output flush, in_valid, in_inst, out_ready,
        input  in_ready, out_valid, out_ir, out_ctrl, out_rs1, out_rs2, out_rd,
               out_imm, out_use_imm, out_is_load, out_reg_write, out_illegal
    );
endinterface

// File: rtl/id_ex_decode_stage.sv
// RV32I/RV64I decode into an ID/EX register with load-use bubbles; 1-cycle latency.
// Backpressure: contents held and in_ready low while out_valid && !out_ready.
module id_ex_decode_stage #(
    parameter int XLEN           = 32,
    parameter int LOAD_USE_STALL = 1
) (
    input  logic                  clock,
    input  logic                  resetn,
    id_ex_decode_stage_if.slave   bus
);
    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [1:0] STALL_INIT =
        (LOAD_USE_STALL > 0) ? 2'(LOAD_USE_STALL - 1) : 2'd0;

    typedef struct packed {
        logic [31:0]     ir;
        logic [3:0]      ctrl;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] imm;
        logic            use_imm;
        logic            is_load;
        logic            reg_write;
        logic            illegal;
    } idex_t;

    typedef enum logic {RUN, STALL} state_t;

    state_t      state, state_nxt;
    logic [1:0]  cnt, cnt_nxt;
    logic        vld_q, vld_nxt;
    idex_t       q, q_nxt, dec;
    logic        dec_is_r;
    logic        load_en, hazard, in_rdy;

    logic [31:0] inst;
    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [3:0]  base_ctrl;
    logic        shift_base, shift_alt, is_shift;

    assign inst   = bus.in_inst;
    assign opcode = inst[6:0];
    assign f3     = inst[14:12];
    assign f7     = inst[31:25];
    assign is_shift = (f3 == 3'b001) || (f3 == 3'b101);

    // RV64 shifts carry a 6-bit shamt, so inst[25] is not part of the funct field.
    assign shift_base = (XLEN == 64) ? (inst[31:26] == 6'b000000) : (f7 == 7'b0000000);
    assign shift_alt  = (XLEN == 64) ? (inst[31:26] == 6'b010000) : (f7 == 7'b0100000);

    always_comb begin
        base_ctrl = 4'h0;
        case (f3)
            3'b000:  base_ctrl = 4'h1;
            3'b001:  base_ctrl = 4'h3;
            3'b101:  base_ctrl = 4'h4;
            3'b010:  base_ctrl = 4'h6;
            3'b011:  base_ctrl = 4'h7;
            3'b100:  base_ctrl = 4'h8;
            3'b110:  base_ctrl = 4'h9;
            default: base_ctrl = 4'hA;
        endcase
    end

    always_comb begin
        dec      = '0;
        dec_is_r = 1'b0;
        dec.ir   = inst;
        dec.rs1  = inst[19:15];
        dec.rs2  = inst[24:20];
        dec.rd   = inst[11:7];
        case (opcode)
            OP_R: begin
                dec_is_r = 1'b1;
                if (f7 == 7'b0000000)                         dec.ctrl = base_ctrl;
                else if (f7 == 7'b0100000 && f3 == 3'b000)    dec.ctrl = 4'h2;
                else if (f7 == 7'b0100000 && f3 == 3'b101)    dec.ctrl = 4'h5;
                else                                          dec.illegal = 1'b1;
            end
            OP_I: begin
                dec.imm     = {{(XLEN-12){inst[31]}}, inst[31:20]};
                dec.use_imm = 1'b1;
                if (!is_shift)                                dec.ctrl = base_ctrl;
                else if (shift_base)                          dec.ctrl = base_ctrl;
                else if (shift_alt && f3 == 3'b101)           dec.ctrl = 4'h5;
                else                                          dec.illegal = 1'b1;
            end
            OP_LD: begin
                dec.imm     = {{(XLEN-12){inst[31]}}, inst[31:20]};
                dec.use_imm = 1'b1;
                dec.is_load = 1'b1;
                dec.ctrl    = 4'h1;
            end
            default: dec.illegal = 1'b1;
        endcase
        if (dec.illegal) begin
            dec.ctrl    = 4'h0;
            dec.imm     = '0;
            dec.use_imm = 1'b0;
            dec.is_load = 1'b0;
        end
        dec.reg_write = !dec.illegal && (dec.rd != 5'd0);
    end

    assign load_en = !vld_q || bus.out_ready;

    // Only rs1 is read by I-type/load, so rs2 matches count for R-type alone.
    assign hazard = (LOAD_USE_STALL > 0) && (state == RUN) && load_en && bus.in_valid &&
                    vld_q && q.is_load && (q.rd != 5'd0) && !dec.illegal &&
                    ((q.rd == dec.rs1) || (dec_is_r && (q.rd == dec.rs2)));

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        vld_nxt   = vld_q;
        q_nxt     = q;
        in_rdy    = 1'b0;
        if (bus.flush) begin
            state_nxt = RUN;
            cnt_nxt   = 2'd0;
            vld_nxt   = 1'b0;
            q_nxt     = '0;
            in_rdy    = 1'b1;
        end else if (state == STALL) begin
            vld_nxt   = 1'b0;
            q_nxt     = '0;
            cnt_nxt   = cnt - 2'd1;
            state_nxt = (cnt == 2'd1) ? RUN : STALL;
        end else if (load_en) begin
            if (hazard) begin
                vld_nxt   = 1'b0;
                q_nxt     = '0;
                cnt_nxt   = STALL_INIT;
                state_nxt = (STALL_INIT != 2'd0) ? STALL : RUN;
            end else begin
                in_rdy  = 1'b1;
                vld_nxt = bus.in_valid;
                q_nxt   = bus.in_valid ? dec : '0;
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= RUN;
            cnt   <= 2'd0;
            vld_q <= 1'b0;
            q     <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            vld_q <= vld_nxt;
            q     <= q_nxt;
        end
    end

    assign bus.in_ready      = in_rdy;
    assign bus.out_valid     = vld_q;
    assign bus.out_ir        = q.ir;
    assign bus.out_ctrl      = q.ctrl;
    assign bus.out_rs1       = q.rs1;
    assign bus.out_rs2       = q.rs2;
    assign bus.out_rd        = q.rd;
    assign bus.out_imm       = q.imm;
    assign bus.out_use_imm   = q.use_imm;
    assign bus.out_is_load   = q.is_load;
    assign bus.out_reg_write = q.reg_write;
    assign bus.out_illegal   = q.illegal;
endmodule
